// File: rtl/bilinear_scale_ctrl.sv
// Frame sequencer for the Q8.8 bilinear datapath: walks destination pixels in raster order,
// fetches the four source neighbours, fires the datapath and writes each result back.
module bilinear_scale_ctrl #(
   parameter int DIM_W  = 10,
   parameter int ADDR_W = 20,
   parameter int ACC_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  src_w,
   input  logic [DIM_W-1:0]  src_h,
   input  logic [DIM_W-1:0]  dst_w,
   input  logic [DIM_W-1:0]  dst_h,
   input  logic [15:0]       step_x,
   input  logic [15:0]       step_y,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              dp_start,
   output logic [7:0]        dp_p00,
   output logic [7:0]        dp_p01,
   output logic [7:0]        dp_p10,
   output logic [7:0]        dp_p11,
   output logic [15:0]       dp_a,
   output logic [15:0]       dp_b,
   input  logic [7:0]        dp_pixel_out,
   input  logic              dp_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);

   localparam int IW = ACC_W - 8;

   typedef enum logic [3:0] {
      S_IDLE, S_CALC, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_FIRE, S_WAITDP, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DIM_W-1:0]    ox_q, ox_d, oy_q, oy_d;
   logic [ACC_W-1:0]    x_acc_q, x_acc_d, y_acc_q, y_acc_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [DIM_W-1:0]    sw_q, sw_d, sh_q, sh_d, dw_q, dw_d, dh_q, dh_d;
   logic [15:0]         stx_q, stx_d, sty_q, sty_d;
   logic [DIM_W-1:0]    x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [15:0]         dp_a_q, dp_a_d, dp_b_q, dp_b_d;
   logic [7:0]          p00_q, p00_d, p01_q, p01_d, p10_q, p10_d, p11_q, p11_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                busy_q, busy_d, done_q, done_d, dp_start_q, dp_start_d;

   logic [DIM_W-1:0]    sw_max, sh_max, cx0, cy0, rd_row, rd_col;
   logic                x_clamped, y_clamped;
   logic [ADDR_W-1:0]   addr_calc;

   function automatic logic [DIM_W-1:0] clamp_idx(input logic [IW-1:0] ipart,
                                                  input logic [DIM_W-1:0] lim);
      if (ipart > IW'(lim)) return lim;
      return DIM_W'(ipart);
   endfunction

   // Saturate at all-ones so a large step never wraps the coordinate back to the origin.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [15:0] step);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + (ACC_W+1)'(step);
      return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
   endfunction

   assign sw_max    = sw_q - DIM_W'(1);
   assign sh_max    = sh_q - DIM_W'(1);
   assign x_clamped = x_acc_q[ACC_W-1:8] > IW'(sw_max);
   assign y_clamped = y_acc_q[ACC_W-1:8] > IW'(sh_max);
   assign cx0       = clamp_idx(x_acc_q[ACC_W-1:8], sw_max);
   assign cy0       = clamp_idx(y_acc_q[ACC_W-1:8], sh_max);
   assign addr_calc = ADDR_W'(rd_row) * ADDR_W'(sw_q) + ADDR_W'(rd_col);

   always_comb begin
      // NOTE: every target gets a default up front so no path through the case infers a latch.
      state_d   = state_q;
      ox_d      = ox_q;      oy_d    = oy_q;
      x_acc_d   = x_acc_q;   y_acc_d = y_acc_q;
      idx_d     = idx_q;
      sw_d      = sw_q;      sh_d    = sh_q;
      dw_d      = dw_q;      dh_d    = dh_q;
      stx_d     = stx_q;     sty_d   = sty_q;
      x0_d      = x0_q;      x1_d    = x1_q;
      y0_d      = y0_q;      y1_d    = y1_q;
      dp_a_d    = dp_a_q;    dp_b_d  = dp_b_q;
      p00_d     = p00_q;     p01_d   = p01_q;
      p10_d     = p10_q;     p11_d   = p11_q;
      rd_addr_d = rd_addr_q;
      rd_row    = y0_q;
      rd_col    = x0_q;

      unique case (state_q)
         S_IDLE: if (start) begin
            sw_d = src_w;  sh_d = src_h;  dw_d = dst_w;  dh_d = dst_h;
            stx_d = step_x;  sty_d = step_y;
            ox_d = '0;  oy_d = '0;  x_acc_d = '0;  y_acc_d = '0;  idx_d = '0;
            state_d = (dst_w == '0 || dst_h == '0) ? S_DONE : S_CALC;
         end
         S_CALC: begin
            x0_d      = cx0;
            x1_d      = (cx0 == sw_max) ? cx0 : cx0 + DIM_W'(1);
            y0_d      = cy0;
            y1_d      = (cy0 == sh_max) ? cy0 : cy0 + DIM_W'(1);
            dp_b_d    = x_clamped ? 16'h0000 : {8'h00, x_acc_q[7:0]};
            dp_a_d    = y_clamped ? 16'h0000 : {8'h00, y_acc_q[7:0]};
            rd_row    = cy0;
            rd_col    = cx0;
            rd_addr_d = addr_calc;
            state_d   = S_RD0;
         end
         S_RD0: begin
            rd_col = x1_q;  rd_addr_d = addr_calc;  state_d = S_RD1;
         end
         S_RD1: begin
            p00_d = rd_data;  rd_row = y1_q;  rd_addr_d = addr_calc;  state_d = S_RD2;
         end
         S_RD2: begin
            p01_d = rd_data;  rd_row = y1_q;  rd_col = x1_q;  rd_addr_d = addr_calc;
            state_d = S_RD3;
         end
         S_RD3:  begin p10_d = rd_data;  state_d = S_LAST; end
         S_LAST: begin p11_d = rd_data;  state_d = S_FIRE; end
         S_FIRE: state_d = S_WAITDP;
         S_WAITDP: if (dp_done) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_CALC;
            if (ox_q == dw_q - DIM_W'(1)) begin
               ox_d    = '0;
               x_acc_d = '0;
               if (oy_q == dh_q - DIM_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  oy_d    = oy_q + DIM_W'(1);
                  y_acc_d = sat_add(y_acc_q, sty_q);
               end
            end else begin
               ox_d    = ox_q + DIM_W'(1);
               x_acc_d = sat_add(x_acc_q, stx_q);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      dp_start_d = (state_d == S_FIRE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ox_q <= '0;  oy_q <= '0;  x_acc_q <= '0;  y_acc_q <= '0;  idx_q <= '0;
         sw_q <= '0;  sh_q <= '0;  dw_q <= '0;  dh_q <= '0;  stx_q <= '0;  sty_q <= '0;
         x0_q <= '0;  x1_q <= '0;  y0_q <= '0;  y1_q <= '0;
         dp_a_q <= '0;  dp_b_q <= '0;
         p00_q <= '0;  p01_q <= '0;  p10_q <= '0;  p11_q <= '0;
         rd_addr_q <= '0;  busy_q <= 1'b0;  done_q <= 1'b0;  dp_start_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates make every flop see the pre-edge value of every other flop.
         state_q <= state_d;
         ox_q <= ox_d;  oy_q <= oy_d;  x_acc_q <= x_acc_d;  y_acc_q <= y_acc_d;  idx_q <= idx_d;
         sw_q <= sw_d;  sh_q <= sh_d;  dw_q <= dw_d;  dh_q <= dh_d;  stx_q <= stx_d;  sty_q <= sty_d;
         x0_q <= x0_d;  x1_q <= x1_d;  y0_q <= y0_d;  y1_q <= y1_d;
         dp_a_q <= dp_a_d;  dp_b_q <= dp_b_d;
         p00_q <= p00_d;  p01_q <= p01_d;  p10_q <= p10_d;  p11_q <= p11_d;
         rd_addr_q <= rd_addr_d;  busy_q <= busy_d;  done_q <= done_d;  dp_start_q <= dp_start_d;
      end
   end

   // The write strobe must land in the same cycle dp_done arrives, so it stays combinational.
   assign wr_en    = (state_q == S_WAITDP) && dp_done;
   assign wr_data  = wr_en ? dp_pixel_out : 8'h00;
   assign wr_addr  = idx_q;
   assign rd_addr  = rd_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign dp_start = dp_start_q;
   assign dp_p00   = p00_q;
   assign dp_p01   = p01_q;
   assign dp_p10   = p10_q;
   assign dp_p11   = p11_q;
   assign dp_a     = dp_a_q;
   assign dp_b     = dp_b_q;

endmodule

// File: tb/tb_bilinear_scale_ctrl.sv
// Directed bench for bilinear_scale_ctrl with a sync-read source RAM and a one-cycle datapath model.
module tb_bilinear_scale_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
   logic [15:0] step_x = '0, step_y = '0;
   logic        busy, done, dp_start, wr_en;
   logic [19:0] rd_addr, wr_addr;
   logic [7:0]  rd_data = '0;
   logic [7:0]  dp_p00, dp_p01, dp_p10, dp_p11, wr_data;
   logic [15:0] dp_a, dp_b;
   logic [7:0]  dp_pixel_out = '0;
   logic        dp_done = 1'b0;

   logic [7:0]  mem [0:15];
   int          n_cmp = 0, n_bad = 0;

   logic [19:0] wa_log[$];
   logic [7:0]  wd_log[$];
   logic [15:0] da_log[$], db_log[$];
   int          done_cnt = 0, busy_cnt = 0, rd_chg = 0;
   logic [19:0] rd_prev = '0;
   int          base_w, base_done, base_busy, base_rd;

   bilinear_scale_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
      .step_x(step_x), .step_y(step_y),
      .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .dp_start(dp_start),
      .dp_p00(dp_p00), .dp_p01(dp_p01), .dp_p10(dp_p10), .dp_p11(dp_p11),
      .dp_a(dp_a), .dp_b(dp_b),
      .dp_pixel_out(dp_pixel_out), .dp_done(dp_done),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr[3:0]];

   function automatic logic [7:0] bilin(input int p00, p01, p10, p11, a, b);
      int top, bot;
      top = p00 * (256 - b) + p01 * b;
      bot = p10 * (256 - b) + p11 * b;
      return 8'((top * (256 - a) + bot * a + 32768) >> 16);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_done <= 1'b0;
      end else begin
         dp_done <= dp_start;
         if (dp_start)
            dp_pixel_out <= bilin(dp_p00, dp_p01, dp_p10, dp_p11, dp_a[7:0], dp_b[7:0]);
      end
   end

   always @(negedge clk) begin
      if (wr_en) begin
         wa_log.push_back(wr_addr);
         wd_log.push_back(wr_data);
         da_log.push_back(dp_a);
         db_log.push_back(dp_b);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (rd_addr != rd_prev) rd_chg <= rd_chg + 1;
      rd_prev <= rd_addr;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_mem(input logic [7:0] m0, m1, m2, m3);
      mem[0] = m0;  mem[1] = m1;  mem[2] = m2;  mem[3] = m3;
   endtask

   // Fires one start and returns the number of edges after the sampling edge until done is seen.
   task automatic run_frame(input logic [9:0] sw, sh, dw, dh, input logic [15:0] sx, sy,
                            input bit extra, output int edges);
      base_w = wa_log.size();  base_done = done_cnt;  base_busy = busy_cnt;  base_rd = rd_chg;
      @(negedge clk);
      src_w = sw;  src_h = sh;  dst_w = dw;  dst_h = dh;  step_x = sx;  step_y = sy;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      edges = -1;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (done) begin
            edges = n;
            break;
         end
         if (extra && (n == 5 || n == 20 || n == 31)) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int edges;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_dp_start", dp_start, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_dp_ab", {dp_a, dp_b}, 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      // 2x2 identity scale
      set_mem(8'd10, 8'd20, 8'd30, 8'd40);
      run_frame(10'd2, 10'd2, 10'd2, 10'd2, 16'h0100, 16'h0100, 1'b0, edges);
      check("id_latency", edges, 32);
      check("id_writes", wa_log.size() - base_w, 4);
      check("id_done_cnt", done_cnt - base_done, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("id_addr%0d", i), wa_log[base_w + i], i);
         check($sformatf("id_data%0d", i), wd_log[base_w + i], 10 * (i + 1));
      end

      // 2x1 -> 3x1 horizontal upscale, last column clamps
      set_mem(8'd0, 8'd200, 8'd0, 8'd0);
      run_frame(10'd2, 10'd1, 10'd3, 10'd1, 16'h0080, 16'h0100, 1'b0, edges);
      check("h_latency", edges, 24);
      check("h_writes", wa_log.size() - base_w, 3);
      check("h_data0", wd_log[base_w + 0], 0);
      check("h_data1", wd_log[base_w + 1], 100);
      check("h_data2", wd_log[base_w + 2], 200);
      check("h_dp_b1", db_log[base_w + 1], 16'h0080);
      check("h_dp_b2", db_log[base_w + 2], 16'h0000);

      // 2x2 -> 3x3 both-axis upscale
      set_mem(8'd0, 8'd100, 8'd100, 8'd200);
      run_frame(10'd2, 10'd2, 10'd3, 10'd3, 16'h0080, 16'h0080, 1'b0, edges);
      check("s_latency", edges, 72);
      check("s_writes", wa_log.size() - base_w, 9);
      check("s_dp_a4", da_log[base_w + 4], 16'h0080);
      check("s_dp_b4", db_log[base_w + 4], 16'h0080);
      check("s_data4", wd_log[base_w + 4], 100);
      check("s_data2", wd_log[base_w + 2], 100);
      check("s_addr8", wa_log[base_w + 8], 8);
      check("s_data8", wd_log[base_w + 8], 200);

      // empty destination frames
      run_frame(10'd2, 10'd2, 10'd0, 10'd2, 16'h0100, 16'h0100, 1'b0, edges);
      check("z_latency", edges, 0);
      check("z_writes", wa_log.size() - base_w, 0);
      check("z_busy_cycles", busy_cnt - base_busy, 1);
      check("z_rd_changes", rd_chg - base_rd, 0);
      check("z_done_cnt", done_cnt - base_done, 1);
      run_frame(10'd2, 10'd2, 10'd2, 10'd0, 16'h0100, 16'h0100, 1'b0, edges);
      check("zh_latency", edges, 0);
      check("zh_writes", wa_log.size() - base_w, 0);

      // reset during RD2 of pixel 1
      set_mem(8'd10, 8'd20, 8'd30, 8'd40);
      base_w = wa_log.size();
      @(negedge clk);
      src_w = 10'd2;  src_h = 10'd2;  dst_w = 10'd2;  dst_h = 10'd2;
      step_x = 16'h0100;  step_y = 16'h0100;  start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("ab_rd_addr_rd2", rd_addr, 3);
      check("ab_writes_before", wa_log.size() - base_w, 1);
      #1 rst = 1'b1;
      #1;
      check("ab_busy", busy, 0);
      check("ab_wr_en", wr_en, 0);
      check("ab_dp_start", dp_start, 0);
      check("ab_done", done, 0);
      @(negedge clk) rst = 1'b0;
      repeat (20) @(negedge clk);
      check("ab_writes_after", wa_log.size() - base_w, 1);
      run_frame(10'd2, 10'd2, 10'd2, 10'd2, 16'h0100, 16'h0100, 1'b0, edges);
      check("ab_latency", edges, 32);
      check("ab_writes", wa_log.size() - base_w, 4);
      check("ab_addr0", wa_log[base_w], 0);
      check("ab_data0", wd_log[base_w], 10);
      check("ab_data3", wd_log[base_w + 3], 40);

      // start pulses while busy are ignored
      run_frame(10'd2, 10'd2, 10'd2, 10'd2, 16'h0100, 16'h0100, 1'b1, edges);
      check("ex_latency", edges, 32);
      check("ex_writes", wa_log.size() - base_w, 4);
      check("ex_done_cnt", done_cnt - base_done, 1);
      check("ex_busy_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
